// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// and drives the IF/ID register with stall hold, skid capture and redirect kill.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrCode,
  output logic [31:0] PC,
  output logic [31:0] PC_4,
  output logic        if_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] skid_q;
  logic [31:0] instr_q, pcr_q, pc4_q;
  logic        vld_q;

  logic [31:0] rpc, pc_inc;
  logic        ld_mem, ld_skid, cap_skid;

  assign rpc    = redirect_pc & ~32'h3;
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!redirect && imem_ready) state_d = S_WAIT;
      S_WAIT: if (imem_rvalid)
                state_d = (kill_q || redirect || !stall) ? S_IDLE : S_HOLD;
      S_HOLD: if (redirect || !stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A response is usable only if no redirect has overtaken it.
  always_comb begin
    imem_req = (state_q == S_IDLE) && !redirect && !rst;
    ld_mem   = (state_q == S_WAIT) && imem_rvalid && !kill_q && !redirect && !stall;
    cap_skid = (state_q == S_WAIT) && imem_rvalid && !kill_q && !redirect && stall;
    ld_skid  = (state_q == S_HOLD) && !redirect && !stall;
  end

  always_comb begin
    pc_d   = pc_q;
    kill_d = kill_q;
    if (redirect)             pc_d = rpc;
    else if (ld_mem || ld_skid) pc_d = pc_inc;
    if (state_q == S_WAIT) begin
      if (imem_rvalid)   kill_d = 1'b0;
      else if (redirect) kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      skid_q  <= 32'h0;
      instr_q <= NOP_INSTR;
      pcr_q   <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      vld_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
      if (cap_skid) skid_q <= imem_rdata;
      if (redirect) begin
        instr_q <= NOP_INSTR;
        vld_q   <= 1'b0;
      end else if (ld_mem || ld_skid) begin
        instr_q <= ld_mem ? imem_rdata : skid_q;
        pcr_q   <= pc_q;
        pc4_q   <= pc_inc;
        vld_q   <= 1'b1;
      end else if (!stall) begin
        instr_q <= NOP_INSTR;
        vld_q   <= 1'b0;
      end
    end
  end

  assign imem_addr = pc_q;
  assign instrCode = instr_q;
  assign PC        = pcr_q;
  assign PC_4      = pc4_q;
  assign if_valid  = vld_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: scoreboard of expected IF/ID entries checked by a monitor,
// plus a second instance exercising PC wrap-around.
module tb_if_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  int          n_tests, n_fail;
  exp_t        sb[$];

  // instance A
  logic        rst, stall, redirect, ready, rvalid, req;
  logic [31:0] rpc, rdata, addr, instr, pc, pc4;
  logic        vld;
  int          lat;

  // instance B
  logic        rst_b, stall_b, redir_b, ready_b, rv_b, req_b, vld_b;
  logic [31:0] rpc_b, rd_b, addr_b, instr_b, pc_b, pc4_b;

  if_fetch_stage #(.RESET_PC(32'h0000_000C)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(rpc),
    .imem_req(req), .imem_addr(addr), .imem_ready(ready), .imem_rvalid(rvalid),
    .imem_rdata(rdata), .instrCode(instr), .PC(pc), .PC_4(pc4), .if_valid(vld));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .redirect(redir_b), .redirect_pc(rpc_b),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(ready_b), .imem_rvalid(rv_b),
    .imem_rdata(rd_b), .instrCode(instr_b), .PC(pc_b), .PC_4(pc4_b), .if_valid(vld_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_a(input logic [31:0] a);
    return (a == 32'h0000_000C) ? 32'h1003_02E7 : (32'hA000_0000 | a);
  endfunction

  // memory model A: issue seen at negedge, response driven lat cycles after the issue edge
  logic        iss_n, pend;
  logic [31:0] addr_n, paddr;
  int          cnt;
  always @(negedge clk) begin
    iss_n  = req && ready;
    addr_n = addr;
  end
  always @(posedge clk) begin
    #1;
    rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        rvalid = 1'b1;
        rdata  = mem_a(paddr);
        pend   = 1'b0;
      end
    end
    if (iss_n) begin
      paddr = addr_n;
      if (lat == 1) begin
        rvalid = 1'b1;
        rdata  = mem_a(addr_n);
      end else begin
        pend = 1'b1;
        cnt  = lat - 1;
      end
    end
  end

  // memory model B: fixed single-cycle latency
  logic        iss_b;
  logic [31:0] addr_bn;
  always @(negedge clk) begin
    iss_b   = req_b && ready_b;
    addr_bn = addr_b;
  end
  always @(posedge clk) begin
    #1;
    rv_b = iss_b;
    rd_b = addr_bn ^ 32'h5A5A_0000;
  end

  // monitor: a new IF/ID entry is one that is valid after an edge without stall
  initial begin : monitor
    logic s, r;
    exp_t e;
    forever begin
      @(posedge clk);
      s = stall;
      r = rst;
      #1;
      if (!r && vld && !s) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_extra: got instr %h pc %h expected no instruction", instr, pc);
        end else begin
          e = sb.pop_front();
          chk("mon_instr", instr, e.instr);
          chk("mon_pc",    pc,    e.pc);
          chk("mon_pc4",   pc4,   e.pc4);
        end
      end
    end
  end

  // instance B: wrap-around of PC+4
  initial begin : wrap_seq
    rst_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; rpc_b = 32'h0; ready_b = 1'b1;
    cyc(); cyc();
    chk("wrap_rst_pc",   pc_b,   32'hFFFF_FFFC);
    chk("wrap_rst_pc4",  pc4_b,  32'h0000_0000);
    chk("wrap_rst_addr", addr_b, 32'hFFFF_FFFC);
    rst_b = 1'b0;
    cyc();
    cyc();
    chk("wrap_pc",    pc_b,    32'hFFFF_FFFC);
    chk("wrap_pc4",   pc4_b,   32'h0000_0000);
    chk("wrap_instr", instr_b, 32'hA5A5_FFFC);
    chk("wrap_vld",   {31'h0, vld_b}, 32'h1);
    chk("wrap_addr2", addr_b,  32'h0000_0000);
    rst_b = 1'b1;
  end

  initial begin : stim
    n_tests = 0; n_fail = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'h0; ready = 1'b1;
    rvalid = 1'b0; rdata = 32'h0; lat = 1; pend = 1'b0; cnt = 0;
    cyc(); cyc();
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc",    pc,    32'h0000_000C);
    chk("rst_pc4",   pc4,   32'h0000_0010);
    chk("rst_vld",   {31'h0, vld}, 32'h0);
    chk("rst_req",   {31'h0, req}, 32'h0);
    rst = 1'b0;
    sb.push_back('{32'h1003_02E7, 32'h0000_000C, 32'h0000_0010});
    cyc();                                   // issue 0xC
    cyc();                                   // load 0xC
    chk("next_addr", addr, 32'h0000_0010);
    chk("next_req",  {31'h0, req}, 32'h1);
    // stall across the 0x10 response
    stall = 1'b1;
    sb.push_back('{32'hA000_0010, 32'h0000_0010, 32'h0000_0014});
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_pc",    pc,    32'h0000_000C);
      chk("hold_instr", instr, 32'h1003_02E7);
      chk("hold_vld",   {31'h0, vld}, 32'h1);
    end
    stall = 1'b0;
    cyc();                                   // 0x10 from skid
    chk("addr_14", addr, 32'h0000_0014);
    lat = 2;
    cyc();                                   // issue 0x14
    redirect = 1'b1; rpc = 32'h0000_0043;
    cyc();                                   // redirect while waiting
    chk("kill_vld",   {31'h0, vld}, 32'h0);
    chk("kill_instr", instr, 32'h0000_0013);
    chk("kill_req",   {31'h0, req}, 32'h0);
    redirect = 1'b0;
    cyc();                                   // stale 0x14 data dropped
    chk("redir_addr", addr, 32'h0000_0040);
    chk("redir_req",  {31'h0, req}, 32'h1);
    chk("drop_vld",   {31'h0, vld}, 32'h0);
    lat = 1;
    sb.push_back('{32'hA000_0040, 32'h0000_0040, 32'h0000_0044});
    cyc(); cyc();                            // fetch 0x40
    stall = 1'b1;
    cyc(); cyc();                            // 0x44 parked in skid
    redirect = 1'b1; rpc = 32'h0000_0080;
    cyc();                                   // redirect + stall in HOLD
    chk("hold_redir_vld",   {31'h0, vld}, 32'h0);
    chk("hold_redir_instr", instr, 32'h0000_0013);
    chk("hold_redir_addr",  addr, 32'h0000_0080);
    redirect = 1'b0; stall = 1'b0;
    sb.push_back('{32'hA000_0080, 32'h0000_0080, 32'h0000_0084});
    cyc(); cyc();                            // fetch 0x80
    lat = 2;
    cyc();                                   // issue 0x84
    rst = 1'b1;
    cyc();                                   // reset while waiting
    chk("mrst_instr", instr, 32'h0000_0013);
    chk("mrst_pc",    pc,    32'h0000_000C);
    chk("mrst_pc4",   pc4,   32'h0000_0010);
    chk("mrst_vld",   {31'h0, vld}, 32'h0);
    chk("mrst_req",   {31'h0, req}, 32'h0);
    chk("mrst_addr",  addr,  32'h0000_000C);
    rst = 1'b0;
    sb.push_back('{32'h1003_02E7, 32'h0000_000C, 32'h0000_0010});
    cyc();                                   // stale rvalid arrives in IDLE
    chk("stale_vld", {31'h0, vld}, 32'h0);
    cyc(); cyc();                            // fresh 0xC fetch lands
    ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("sb_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
